// File: rtl/fib_pkg.sv
// Shared types and default parameter values for the Fibonacci term generator.
package fib_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } fib_state_e;

  localparam int unsigned DefWidth    = 8;
  localparam int unsigned DefCntW     = 8;
  localparam int unsigned DefSaturate = 0;

endpackage

// File: rtl/fib_adder.sv
// Adds two Fibonacci terms at WIDTH+1 bits; carry reports the true overflow even when clamped.
module fib_adder
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned SATURATE = DefSaturate
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] full;

  always_comb begin
    full  = {1'b0, a} + {1'b0, b};
    carry = full[WIDTH];
    sum   = full[WIDTH-1:0];
    if ((SATURATE != 0) && carry) begin
      sum = '1;
    end
  end

endmodule

// File: rtl/fibonacci_gen.sv
// Streams n_terms Fibonacci terms from two seeds over a valid/ready handshake.
module fibonacci_gen
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned CNT_W    = DefCntW,
  parameter int unsigned SATURATE = DefSaturate
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] n_terms,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  output logic             busy,
  output logic [WIDTH-1:0] out_term,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             done,
  output logic             overflow
);

  fib_state_e       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             is_last;

  fib_adder #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_adder (
    .a     (prev_q),
    .b     (cur_q),
    .sum   (sum),
    .carry (carry)
  );

  assign is_last = (k_q == (n_q - CNT_W'(1)));

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    k_d     = k_q;
    n_d     = n_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_d     = n_terms;
          cur_d   = seed0;
          // seed1 parks in prev so the first advance just swaps the two registers
          prev_d  = seed1;
          k_d     = '0;
          ovf_d   = 1'b0;
          state_d = (n_terms == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StDone;
        end else if (out_ready) begin
          if (is_last) begin
            state_d = StDone;
          end else begin
            k_d    = k_q + CNT_W'(1);
            prev_d = cur_q;
            if (k_q == '0) begin
              cur_d = prev_q;
            end else begin
              cur_d = sum;
              if (carry) begin
                ovf_d = 1'b1;
              end
            end
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      prev_q  <= '0;
      cur_q   <= '0;
      k_q     <= '0;
      n_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      k_q     <= k_d;
      n_q     <= n_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign out_valid = (state_q == StRun);
  assign out_last  = (state_q == StRun) && is_last;
  assign done      = (state_q == StDone);
  assign out_term  = cur_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_fibonacci_gen.sv
// Scoreboard bench: stimulus queues expected terms and done cycles, a negedge monitor checks them.
module tb_fibonacci_gen;

  typedef struct packed {
    logic [7:0] term;
    logic       last;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] n_terms;
  logic [7:0] seed0;
  logic [7:0] seed1;
  logic       out_ready;

  logic       busy0, valid0, last0, done0, ovf0;
  logic       busy1, valid1, last1, done1, ovf1;
  logic [7:0] term0, term1;

  exp_t q0[$];
  exp_t q1[$];
  int   dq0[$];
  int   dq1[$];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   end_req = 1'b0;
  bit   hold[2];
  logic [7:0] held[2];

  logic [7:0] fib_w[15] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34,
                            8'd55, 8'd89, 8'd144, 8'd233, 8'd121};
  logic [7:0] t4[4]     = '{8'd2, 8'd3, 8'd5, 8'd8};
  bit         rdy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  fibonacci_gen #(.WIDTH(8), .CNT_W(8), .SATURATE(0)) u_wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .n_terms   (n_terms),
    .seed0     (seed0),
    .seed1     (seed1),
    .busy      (busy0),
    .out_term  (term0),
    .out_valid (valid0),
    .out_ready (out_ready),
    .out_last  (last0),
    .done      (done0),
    .overflow  (ovf0)
  );

  fibonacci_gen #(.WIDTH(8), .CNT_W(8), .SATURATE(1)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .n_terms   (n_terms),
    .seed0     (seed0),
    .seed1     (seed1),
    .busy      (busy1),
    .out_term  (term1),
    .out_valid (valid1),
    .out_ready (out_ready),
    .out_last  (last1),
    .done      (done1),
    .overflow  (ovf1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int d, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL dut%0d %s: got %0d expected %0d (cycle %0d)", d, name, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input logic [7:0] t, input logic l, input logic o);
    exp_t e;
    e.term = t;
    e.last = l;
    e.ovf  = o;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic push_both(input logic [7:0] t, input logic l, input logic o);
    push(0, t, l, o);
    push(1, t, l, o);
  endtask

  task automatic push_done(input int c);
    dq0.push_back(c);
    dq1.push_back(c);
  endtask

  task automatic mon_one(input int d, input logic b, input logic v, input logic l,
                         input logic dn, input logic o, input logic [7:0] t);
    exp_t e;
    int   c;
    if (!rst_n) begin
      chk(d, "rst_busy", int'(b), 0);
      chk(d, "rst_valid", int'(v), 0);
      chk(d, "rst_last", int'(l), 0);
      chk(d, "rst_done", int'(dn), 0);
      chk(d, "rst_overflow", int'(o), 0);
      chk(d, "rst_term", int'(t), 0);
      hold[d] = 1'b0;
      return;
    end
    chk(d, "busy_vs_valid", int'(b), int'(v));
    if (hold[d] && v) chk(d, "hold_term", int'(t), int'(held[d]));
    hold[d] = v && !out_ready;
    held[d] = t;
    if (v && out_ready) begin
      if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
        chk(d, "unexpected_term", int'(t), -1);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk(d, "term", int'(t), int'(e.term));
        chk(d, "last", int'(l), int'(e.last));
        chk(d, "overflow", int'(o), int'(e.ovf));
      end
    end
    if (dn) begin
      if ((d == 0) ? (dq0.size() == 0) : (dq1.size() == 0)) begin
        chk(d, "unexpected_done_cycle", cyc, -1);
      end else begin
        c = (d == 0) ? dq0.pop_front() : dq1.pop_front();
        chk(d, "done_cycle", cyc, c);
      end
    end
  endtask

  always @(negedge clk) begin
    mon_one(0, busy0, valid0, last0, done0, ovf0, term0);
    mon_one(1, busy1, valid1, last1, done1, ovf1, term1);
    if (end_req) begin
      chk(0, "terms_left", q0.size(), 0);
      chk(1, "terms_left", q1.size(), 0);
      chk(0, "dones_left", dq0.size(), 0);
      chk(1, "dones_left", dq1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    int base;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    n_terms = '0; seed0 = '0; seed1 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Ten terms back to back; start held high through RUN and DONE must be ignored.
    for (int i = 0; i < 10; i++) push_both(fib_w[i], i == 9, 1'b0);
    seed0 = 8'd0; seed1 = 8'd1; n_terms = 8'd10; start = 1'b1;
    @(posedge clk); #1;
    base = cyc;
    push_done(base + 10);
    repeat (11) @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk); #1;

    // Fifteen terms: wrap gives 121, clamp gives 255, overflow flagged on the last term.
    for (int i = 0; i < 15; i++) begin
      push(0, fib_w[i], i == 14, i == 14);
      push(1, (i == 14) ? 8'd255 : fib_w[i], i == 14, i == 14);
    end
    n_terms = 8'd15; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = cyc;
    push_done(base + 15);
    repeat (17) @(posedge clk); #1;

    // Empty sequence: done only, one cycle after start.
    n_terms = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push_done(cyc);
    repeat (2) @(posedge clk); #1;

    // Single term 7; overflow must have been cleared by this start.
    push_both(8'd7, 1'b1, 1'b0);
    seed0 = 8'd7; seed1 = 8'd9; n_terms = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push_done(cyc + 1);
    repeat (3) @(posedge clk); #1;

    // Back-pressure pattern 1,0,0,1 repeated over a 2/3 seeded run.
    for (int i = 0; i < 4; i++) push_both(t4[i], i == 3, 1'b0);
    seed0 = 8'd2; seed1 = 8'd3; n_terms = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = cyc;
    push_done(base + 8);
    for (int i = 0; i < 8; i++) begin
      out_ready = rdy_pat[i % 4];
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Abort while term 3 is presented with out_ready high.
    for (int i = 0; i < 4; i++) push_both(fib_w[i], 1'b0, 1'b0);
    seed0 = 8'd0; seed1 = 8'd1; n_terms = 8'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = cyc;
    push_done(base + 4);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Abort in IDLE has no effect.
    abort = 1'b1;
    repeat (2) @(posedge clk); #1;
    abort = 1'b0;

    // Reset mid-run after two accepted terms.
    push_both(8'd0, 1'b0, 1'b0);
    push_both(8'd1, 1'b0, 1'b0);
    n_terms = 8'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-term run right after reset.
    push_both(8'd5, 1'b0, 1'b0);
    push_both(8'd6, 1'b1, 1'b0);
    seed0 = 8'd5; seed1 = 8'd6; n_terms = 8'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push_done(cyc + 2);
    repeat (4) @(posedge clk); #1;

    end_req = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL monitor did not reach the summary");
    $fatal(1, "bench stalled");
  end

endmodule

// File: doc/fibonacci_gen.md
FIBONACCI_GEN -- requirements
Module: fibonacci_gen

Interface
REQ-001 Parameter: WIDTH, 8, bit width of seeds, terms and adder.
REQ-002 Parameter: CNT_W, 8, bit width of term-count input and internal term index.
REQ-003 Parameter: SATURATE, 0, 0 = terms wrap mod 2^WIDTH; 1 = terms clamp at all-ones.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 start  in  1  request a new sequence; sampled only in IDLE.
REQ-007 abort  in  1  synchronous cancel of a running sequence.
REQ-008 n_terms  in  CNT_W  number of terms to emit.
REQ-009 seed0  in  WIDTH  term 0.
REQ-010 seed1  in  WIDTH  term 1.
REQ-011 busy  out  1  high in RUN.
REQ-012 out_term  out  WIDTH  current term.
REQ-013 out_valid  out  1  out_term is valid.
REQ-014 out_ready  in  1  consumer accepts out_term when out_valid && out_ready.
REQ-015 out_last  out  1  qualifies the final term of a sequence.
REQ-016 done  out  1  one-cycle pulse at sequence end (normal, empty or aborted).
REQ-017 overflow  out  1  sticky per sequence; set when any emitted term's true sum exceeded 2^WIDTH-1.

Function
REQ-018 FSM states IDLE, RUN, DONE; DONE lasts exactly one cycle and drives done=1, then returns to IDLE.
REQ-019 IDLE: start=1 latches n_terms, seed0, seed1, clears overflow and term index k=0; n_terms>0 -> RUN, n_terms=0 -> DONE with no term emitted.
REQ-020 Latency: start accepted at edge c -> out_valid=1 with term 0 (seed0) from edge c+1.
REQ-021 Term k: k=0 seed0, k=1 seed1, k>=2 t(k-1)+t(k-2) computed at WIDTH+1 bits; low WIDTH bits emitted when SATURATE=0, all-ones when carry set and SATURATE=1.
REQ-022 Once saturated (SATURATE=1), all later terms of the sequence remain all-ones.
REQ-023 In RUN out_valid=1 every cycle; state, k and out_term advance only on handshake (out_valid && out_ready); otherwise all hold stable.
REQ-024 out_last=1 exactly when k = n_terms-1; handshake on last term -> DONE.
REQ-025 n_terms=1 emits seed0 only; n_terms=2 emits seed0, seed1.
REQ-026 overflow sets in the cycle the overflowing term is presented and holds until next accepted start or reset.
REQ-027 abort=1 in RUN -> DONE next edge, out_valid drops, no further terms; abort has priority over a simultaneous handshake; abort ignored in IDLE/DONE.
REQ-028 start while RUN or DONE is ignored (not queued).
REQ-029 k counter is CNT_W bits and never wraps within a sequence (n_terms <= 2^CNT_W-1).

Reset
REQ-030 reset=0 asynchronously forces IDLE, k=0, busy=0, out_valid=0, out_last=0, done=0, overflow=0, out_term=0, including mid-sequence.
REQ-031 First start is sampled on the first rising edge after reset deasserts.

Structure
REQ-032 Package fib_pkg holds the state enum (IDLE, RUN, DONE) and default parameter constants.
REQ-033 One sub-module fib_adder: WIDTH-parametric add of two terms producing sum and carry, with SATURATE clamp.
REQ-034 Two term registers (previous, current), term index counter and FSM are held in fibonacci_gen; no other sub-modules.

Verification
REQ-035 WIDTH=8, seeds 0/1, n_terms=10, out_ready=1 -> 0,1,1,2,3,5,8,13,21,34 on consecutive cycles, out_last on 34, done next cycle, overflow=0.
REQ-036 SATURATE=0, seeds 0/1, n_terms=15 -> term13=233, term14=121, overflow=1 from term14; SATURATE=1 -> term14=255.
REQ-037 n_terms=0 -> no out_valid, done pulses at start+1; n_terms=1 seeds 7/9 -> single term 7 with out_last.
REQ-038 out_ready toggling 1,0,0,1 during seeds 2/3 run -> 2,3,5,8 each held stable while out_ready=0, no skipped or repeated terms.
REQ-039 abort asserted with out_ready=1 at term3 -> term3 not advanced, done next edge; reset=0 mid-RUN -> all outputs 0 immediately, IDLE.
